// File: rtl/rs232_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rs232_pkg : framing constants and state encoding for rs232_tx/_rx  |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
package rs232_pkg;

   localparam int RS232_DATA_BITS = 8;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_STOP    = 3'd3;
   localparam logic [2:0] ST_RECOVER = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_START   = ST_START,
      S_DATA    = ST_DATA,
      S_STOP    = ST_STOP,
      S_RECOVER = ST_RECOVER
   } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/rs232_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rs232_sync : 2-flop synchronizer for an asynchronous input         |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module rs232_sync #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VALUE;
         sync_q <= RESET_VALUE;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/rs232_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rs232_rx : oversampling 8N1 serial receiver, configurable polarity |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module rs232_rx
   import rs232_pkg::*;
#(
   parameter int   OVERSAMPLE = 16,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic                       CLK_RX,
   input  logic                       RST,
   input  logic                       RX,
   output logic [RS232_DATA_BITS-1:0] DATA,
   output logic                       DONE,
   output logic                       ERR,
   output logic                       BUSY
);

   localparam int                TICK_W   = $clog2(OVERSAMPLE);
   localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);

   logic rx_s;

   rx_state_e                  state_q,   state_d;
   logic [TICK_W-1:0]          tick_q,    tick_d;
   logic [2:0]                 bit_idx_q, bit_idx_d;
   logic [RS232_DATA_BITS-1:0] shreg_q,   shreg_d;
   logic [RS232_DATA_BITS-1:0] data_q,    data_d;
   logic                       done_q,    done_d;
   logic                       err_q,     err_d;

   rs232_sync #(
      .RESET_VALUE (IDLE_LEVEL)
   ) u_sync (
      .clk (CLK_RX),
      .rst (RST),
      .d   (RX),
      .q   (rx_s)
   );

   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            tick_d = '0;
            if (rx_s != IDLE_LEVEL) begin
               state_d = S_START;
            end
         end

         S_START: begin
            tick_d = tick_q + 1'b1;
            if (tick_q == TICK_MID) begin
               tick_d    = '0;
               bit_idx_d = '0;
               // A start level that has vanished by mid-bit is treated as noise.
               state_d   = (rx_s != IDLE_LEVEL) ? S_DATA : S_IDLE;
            end
         end

         S_DATA: begin
            tick_d = tick_q + 1'b1;
            if (tick_q == TICK_END) begin
               tick_d  = '0;
               shreg_d = {rx_s, shreg_q[RS232_DATA_BITS-1:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end

         S_STOP: begin
            tick_d = tick_q + 1'b1;
            if (tick_q == TICK_END) begin
               tick_d = '0;
               if (rx_s == IDLE_LEVEL) begin
                  data_d  = shreg_q;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_RECOVER;
               end
            end
         end

         S_RECOVER: begin
            // Hold off until the line idles so a stuck start level cannot retrigger.
            tick_d = '0;
            if (rx_s == IDLE_LEVEL) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            tick_d  = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_RX) begin
      if (RST) begin
         state_q   <= S_IDLE;
         tick_q    <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign DATA = data_q;
   assign DONE = done_q;
   assign ERR  = err_q;
   assign BUSY = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rs232_rx.sv
`default_nettype none
// Self-checking bench for rs232_rx (OVERSAMPLE=16, idle-low line):
// table of good frames plus hand-written glitch, framing-error and reset sequences.
module tb_rs232_rx;

   localparam logic IDLE_LVL = 1'b0;
   // DONE/ERR appear this many TB cycles after the start bit is driven:
   // 2 synchronizer cycles to reach rx_s, then S+153.
   localparam int   LATENCY  = 155;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = IDLE_LVL;
   logic [7:0] data;
   logic       done;
   logic       err;
   logic       busy;

   int cyc     = 0;
   int n_total = 0;
   int n_pass  = 0;
   int pulses  = 0;

   logic [7:0] exp_held = 8'h00;
   int last_done_cyc = 0;
   int prev_done_cyc = 0;

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         due;
   } sb_t;

   typedef struct {
      logic [7:0] data;
      int         p_even;
      int         p_odd;
      logic [7:0] exp_data;
   } vec_t;

   sb_t  sb[$];
   sb_t  e;
   vec_t vecs[6];

   rs232_rx #(
      .OVERSAMPLE (16),
      .IDLE_LEVEL (IDLE_LVL)
   ) dut (
      .CLK_RX (clk),
      .RST    (rst),
      .RX     (rx),
      .DATA   (data),
      .DONE   (done),
      .ERR    (err),
      .BUSY   (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push(input logic [7:0] d, input logic is_err);
      sb_t s;
      s.data = d;
      s.err  = is_err;
      s.due  = cyc + LATENCY;
      sb.push_back(s);
   endtask

   // Drives one frame starting at the current negedge. Bit k uses p_even or
   // p_odd by parity of k; the stop bit lasts stop_len periods. If abort_bit
   // is >= 0, returns halfway through that data bit.
   task automatic send_frame(input logic [7:0] b, input int pe, input int po,
                             input logic stop_lvl, input int stop_len, input int abort_bit);
      logic [9:0] bits;
      int p;
      bits = {stop_lvl, b, ~IDLE_LVL};
      for (int k = 0; k < 10; k++) begin
         p = (k % 2 == 0) ? pe : po;
         if (k == 9) p = p * stop_len;
         rx = bits[k];
         if (abort_bit >= 0 && k == abort_bit + 1) begin
            repeat (p / 2) @(negedge clk);
            return;
         end
         repeat (p) @(negedge clk);
      end
      rx = IDLE_LVL;
   endtask

   // Scoreboard: pops an expectation on every DONE/ERR, and flags any
   // expectation whose due cycle passes without a pulse.
   always @(negedge clk) begin
      if (done || err) begin
         pulses++;
         if (sb.size() == 0) begin
            check("unexpected_pulse", {30'd0, done, err}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("pulse_cycle", cyc, e.due);
            check("pulse_kind", {30'd0, done, err}, e.err ? 32'd1 : 32'd2);
            if (!e.err) begin
               check("done_data", {24'd0, data}, {24'd0, e.data});
               exp_held      = e.data;
               prev_done_cyc = last_done_cyc;
               last_done_cyc = cyc;
            end else begin
               check("err_data_held", {24'd0, data}, {24'd0, exp_held});
            end
         end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
         check("missing_pulse", 32'd0, 32'd1);
         void'(sb.pop_front());
      end
   end

   initial begin
      int busy_cnt;
      int pulses_before;

      vecs[0] = '{8'hA5, 16, 16, 8'hA5};
      vecs[1] = '{8'h55, 16, 16, 8'h55};
      vecs[2] = '{8'h01, 16, 16, 8'h01};
      vecs[3] = '{8'h80, 16, 16, 8'h80};
      vecs[4] = '{8'h96, 15, 17, 8'h96};
      vecs[5] = '{8'h96, 17, 15, 8'h96};

      rst = 1'b1;
      rx  = IDLE_LVL;
      repeat (3) @(negedge clk);
      check("reset_data", {24'd0, data}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_err",  {31'd0, err},  32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         push(vecs[i].exp_data, 1'b0);
         send_frame(vecs[i].data, vecs[i].p_even, vecs[i].p_odd, IDLE_LVL, 1, -1);
         repeat (10) @(negedge clk);
         check("table_data", {24'd0, data}, {24'd0, vecs[i].exp_data});
      end

      // Back-to-back frames with no idle gap
      push(8'h00, 1'b0);
      send_frame(8'h00, 16, 16, IDLE_LVL, 1, -1);
      push(8'hFF, 1'b0);
      send_frame(8'hFF, 16, 16, IDLE_LVL, 1, -1);
      repeat (10) @(negedge clk);
      check("b2b_spacing", last_done_cyc - prev_done_cyc, 32'd160);
      check("b2b_data", {24'd0, data}, 32'h0000_00FF);

      // Glitch: 4-cycle start-level pulse
      pulses_before = pulses;
      busy_cnt      = 0;
      for (int j = 0; j < 34; j++) begin
         rx = (j < 4) ? ~IDLE_LVL : IDLE_LVL;
         @(negedge clk);
         busy_cnt += busy;
      end
      check("glitch_busy_cycles", busy_cnt, 32'd8);
      check("glitch_no_pulse", pulses - pulses_before, 32'd0);
      check("glitch_data", {24'd0, data}, {24'd0, exp_held});

      // Framing error: stop bit held at start level for 2 bit periods
      push(8'h3C, 1'b1);
      fork
         send_frame(8'h3C, 16, 16, ~IDLE_LVL, 2, -1);
         begin
            repeat (170) @(negedge clk);
            check("recover_busy_high", {31'd0, busy}, 32'd1);
         end
      join
      repeat (4) @(negedge clk);
      check("recover_busy_low", {31'd0, busy}, 32'd0);
      check("ferr_data_held", {24'd0, data}, 32'h0000_00FF);

      // Reset during data bit 4
      send_frame(8'h5A, 16, 16, IDLE_LVL, 1, 4);
      rst = 1'b1;
      rx  = IDLE_LVL;
      @(negedge clk);
      check("midreset_data", {24'd0, data}, 32'd0);
      check("midreset_done", {31'd0, done}, 32'd0);
      check("midreset_err",  {31'd0, err},  32'd0);
      check("midreset_busy", {31'd0, busy}, 32'd0);
      exp_held = 8'h00;
      rst = 1'b0;
      repeat (20) @(negedge clk);
      push(8'h81, 1'b0);
      send_frame(8'h81, 16, 16, IDLE_LVL, 1, -1);
      repeat (10) @(negedge clk);
      check("after_reset_data", {24'd0, data}, 32'h0000_0081);

      for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
      check("scoreboard_drain", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
